// File: rtl/mf_pll_pkg.sv
// Shared defaults and width helpers for the PLL slip-register channels.
package mf_pll_pkg;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_DEPTH = 8;
    localparam int DEF_GUARD = 3;

    // Tap-index width: at least one bit even for a two-stage line.
    function automatic int sel_w(input int depth);
        int w;
        w = $clog2(depth);
        return (w < 1) ? 1 : w;
    endfunction

    // Guard counter must hold the value GUARD itself.
    function automatic int guard_w(input int guard);
        int w;
        w = $clog2(guard + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/mf_pll_slip_chan.sv
// One slip-register channel: tapped delay line, slip-controlled tap select
// and a guard counter that blanks further slips after each accepted one.
module mf_pll_slip_chan
    import mf_pll_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int GUARD = DEF_GUARD,
    localparam int SEL_W = sel_w(DEPTH),
    localparam int GW    = guard_w(GUARD)
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             prn,
    input  logic             ena,
    input  logic             d,
    input  logic             slip,
    output logic             q,
    output logic [SEL_W-1:0] sel,
    output logic             busy,
    output logic             wrap
);

    // Power-up contents match the clrn=0 state.
    logic [DEPTH-1:0] stage_reg = '0;
    logic [DEPTH-1:0] stage_shift;
    logic [SEL_W-1:0] sel_reg   = '0;
    logic [SEL_W-1:0] sel_next;
    logic [GW-1:0]    guard_reg = '0;
    logic [GW-1:0]    guard_next;
    logic             q_reg     = 1'b0;
    logic             busy_reg  = 1'b0;
    logic             wrap_reg  = 1'b0;
    logic             wrap_next;
    logic             accept;

    assign stage_shift[0] = d;

    generate
        for (genvar gi = 1; gi < DEPTH; gi++) begin : g_shift
            assign stage_shift[gi] = stage_reg[gi-1];
        end
    endgenerate

    // busy_reg mirrors guard_reg != 0, so a slip is taken the first idle cycle.
    assign accept = slip & ~busy_reg;

    always_comb begin
        sel_next   = sel_reg;
        wrap_next  = 1'b0;
        guard_next = (guard_reg == '0) ? '0 : guard_reg - GW'(1);
        if (accept) begin
            guard_next = GW'(GUARD);
            if (sel_reg == SEL_W'(DEPTH - 1)) begin
                sel_next  = '0;
                wrap_next = 1'b1;
            end else begin
                sel_next = sel_reg + SEL_W'(1);
            end
        end
    end

    // Preset outranks clear; both discard any coincident slip.
    always_ff @(posedge clk) begin
        if (!prn) begin
            stage_reg <= '1;
            q_reg     <= 1'b1;
            sel_reg   <= '0;
            guard_reg <= '0;
            busy_reg  <= 1'b0;
            wrap_reg  <= 1'b0;
        end else if (!clrn) begin
            stage_reg <= '0;
            q_reg     <= 1'b0;
            sel_reg   <= '0;
            guard_reg <= '0;
            busy_reg  <= 1'b0;
            wrap_reg  <= 1'b0;
        end else begin
            if (ena) begin
                stage_reg <= stage_shift;
                q_reg     <= stage_shift[sel_reg];
            end
            sel_reg   <= sel_next;
            guard_reg <= guard_next;
            busy_reg  <= (guard_next != '0);
            wrap_reg  <= wrap_next;
        end
    end

    assign q    = q_reg;
    assign sel  = sel_reg;
    assign busy = busy_reg;
    assign wrap = wrap_reg;

endmodule

// File: rtl/mf_pll_slip_reg.sv
// Multi-channel PLL slip register: WIDTH independent slip channels with
// their per-channel outputs packed side by side.
module mf_pll_slip_reg
    import mf_pll_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int GUARD = DEF_GUARD,
    localparam int SEL_W = sel_w(DEPTH)
) (
    input  logic                   clk,
    input  logic                   clrn,
    input  logic                   prn,
    input  logic [WIDTH-1:0]       ena,
    input  logic [WIDTH-1:0]       d,
    input  logic [WIDTH-1:0]       slip,
    output logic [WIDTH-1:0]       q,
    output logic [WIDTH*SEL_W-1:0] sel,
    output logic [WIDTH-1:0]       busy,
    output logic [WIDTH-1:0]       wrap
);

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chan
            mf_pll_slip_chan #(
                .DEPTH (DEPTH),
                .GUARD (GUARD)
            ) u_chan (
                .clk  (clk),
                .clrn (clrn),
                .prn  (prn),
                .ena  (ena[gi]),
                .d    (d[gi]),
                .slip (slip[gi]),
                .q    (q[gi]),
                .sel  (sel[gi*SEL_W +: SEL_W]),
                .busy (busy[gi]),
                .wrap (wrap[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_mf_pll_slip_reg.sv
// Directed bench for mf_pll_slip_reg (WIDTH=4, DEPTH=8, GUARD=3).
module tb_mf_pll_slip_reg;

    localparam int WIDTH = 4;
    localparam int DEPTH = 8;
    localparam int GUARD = 3;
    localparam int SEL_W = 3;

    logic                   clk = 1'b0;
    logic                   clrn, prn;
    logic [WIDTH-1:0]       ena, d, slip;
    logic [WIDTH-1:0]       q, busy, wrap;
    logic [WIDTH*SEL_W-1:0] sel;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       clrn, prn, ena, d, slip;
        logic       q, busy, wrap;
        logic [2:0] sel;
    } vec_t;

    vec_t vecs[$];

    mf_pll_slip_reg #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .GUARD (GUARD)
    ) dut (
        .clk  (clk),
        .clrn (clrn),
        .prn  (prn),
        .ena  (ena),
        .d    (d),
        .slip (slip),
        .q    (q),
        .sel  (sel),
        .busy (busy),
        .wrap (wrap)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic c, input logic p, input logic e, input logic dd,
                       input logic s, input logic eq, input logic [2:0] es,
                       input logic eb, input logic ew);
        vec_t v;
        v.clrn = c; v.prn = p; v.ena = e; v.d = dd; v.slip = s;
        v.q = eq; v.sel = es; v.busy = eb; v.wrap = ew;
        vecs.push_back(v);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [WIDTH*SEL_W-1:0] rep_sel(input logic [2:0] s);
        return {WIDTH{s}};
    endfunction

    task automatic do_reset();
        clrn = 1'b0; prn = 1'b1; ena = '0; d = '0; slip = '0;
        step();
        step();
        clrn = 1'b1;
    endtask

    initial begin
        clrn = 1'b1; prn = 1'b1; ena = '0; d = '0; slip = '0;

        // power-up state equals the cleared state
        #1;
        chk("init_q", 32'(q), 32'h0);
        chk("init_sel", 32'(sel), 32'h0);
        chk("init_busy", 32'(busy), 32'h0);

        //  clrn prn ena d slip | q sel busy wrap
        add(0, 1, 0, 0, 0,  0, 0, 0, 0);
        add(0, 1, 0, 0, 0,  0, 0, 0, 0);
        add(1, 1, 1, 1, 0,  1, 0, 0, 0);
        add(1, 1, 1, 0, 0,  0, 0, 0, 0);
        add(1, 1, 1, 0, 1,  0, 1, 1, 0);
        add(1, 1, 1, 1, 1,  0, 1, 1, 0);
        add(1, 1, 1, 0, 1,  1, 1, 1, 0);
        add(1, 1, 1, 0, 1,  0, 1, 0, 0);
        add(1, 1, 1, 1, 1,  0, 2, 1, 0);
        add(1, 1, 0, 1, 0,  0, 2, 1, 0);
        add(1, 1, 0, 0, 0,  0, 2, 1, 0);
        add(1, 1, 0, 1, 0,  0, 2, 0, 0);
        add(1, 1, 0, 0, 1,  0, 3, 1, 0);
        add(1, 1, 1, 0, 0,  0, 3, 1, 0);
        add(1, 1, 1, 0, 0,  0, 3, 1, 0);
        add(1, 1, 1, 1, 0,  1, 3, 0, 0);
        add(1, 1, 0, 0, 1,  1, 4, 1, 0);
        add(1, 1, 0, 0, 1,  1, 4, 1, 0);
        add(1, 1, 0, 0, 1,  1, 4, 1, 0);
        add(1, 1, 0, 0, 1,  1, 4, 0, 0);
        add(1, 1, 0, 0, 1,  1, 5, 1, 0);
        add(0, 0, 1, 0, 1,  1, 0, 0, 0);
        add(0, 1, 1, 0, 1,  0, 0, 0, 0);
        add(1, 1, 1, 1, 1,  1, 1, 1, 0);
        add(0, 1, 1, 1, 1,  0, 0, 0, 0);
        add(1, 1, 0, 0, 1,  0, 1, 1, 0);

        foreach (vecs[i]) begin
            clrn = vecs[i].clrn;
            prn  = vecs[i].prn;
            ena  = {WIDTH{vecs[i].ena}};
            d    = {WIDTH{vecs[i].d}};
            slip = {WIDTH{vecs[i].slip}};
            step();
            chk($sformatf("vec%0d_q", i), 32'(q), 32'({WIDTH{vecs[i].q}}));
            chk($sformatf("vec%0d_sel", i), 32'(sel), 32'(rep_sel(vecs[i].sel)));
            chk($sformatf("vec%0d_busy", i), 32'(busy), 32'({WIDTH{vecs[i].busy}}));
            chk($sformatf("vec%0d_wrap", i), 32'(wrap), 32'({WIDTH{vecs[i].wrap}}));
            $display("vec %0d: q=%h sel=%h busy=%h wrap=%h", i, q, sel, busy, wrap);
        end

        // held slip: one accept every GUARD+1 cycles, single wrap at the 8th accept
        do_reset();
        ena = '1; d = '0; slip = '1;
        for (int i = 1; i <= 40; i++) begin
            step();
            chk($sformatf("held%0d_sel", i), 32'(sel), 32'(rep_sel(3'(((i - 1) / 4 + 1) % 8))));
            chk($sformatf("held%0d_busy", i), 32'(busy), 32'(((i - 1) % 4 != 3) ? 4'hf : 4'h0));
            chk($sformatf("held%0d_wrap", i), 32'(wrap), 32'((i == 29) ? 4'hf : 4'h0));
            $display("held %0d: sel=%h busy=%h wrap=%h", i, sel, busy, wrap);
        end
        chk("held_final_sel", 32'(sel), 32'(rep_sel(3'd2)));

        // three spaced slips with ena low, then a walking one must appear after 4 enabled edges
        do_reset();
        ena = '0; d = '0;
        for (int i = 1; i <= 12; i++) begin
            slip = (i == 1 || i == 5 || i == 9) ? '1 : '0;
            step();
        end
        chk("walk_sel", 32'(sel), 32'(rep_sel(3'd3)));
        slip = '0; ena = '1;
        for (int k = 1; k <= 8; k++) begin
            d = (k == 1) ? '1 : '0;
            step();
            chk($sformatf("walk%0d_q", k), 32'(q), 32'((k == 4) ? 4'hf : 4'h0));
            $display("walk %0d: q=%h sel=%h", k, q, sel);
        end

        // channel independence: ch1 busy does not block ch0
        do_reset();
        ena = '0; slip = 4'b0010;
        step();
        chk("indep1_sel", 32'(sel), 32'(12'b000_000_001_000));
        chk("indep1_busy", 32'(busy), 32'(4'b0010));
        slip = 4'b0011;
        step();
        chk("indep2_sel", 32'(sel), 32'(12'b000_000_001_001));
        chk("indep2_busy", 32'(busy), 32'(4'b0011));
        $display("indep: sel=%h busy=%h", sel, busy);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mf_pll_slip_reg.md
MF_PLL_SLIP_REG -- requirements
Module: mf_pll_slip_reg

Interface
REQ-001 Parameter WIDTH, default 4, number of independent channels (>=1).
REQ-002 Parameter DEPTH, default 8, delay-line stages per channel (>=2, any integer).
REQ-003 Parameter GUARD, default 3, slip-blanking cycles after an accepted slip (>=1).
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 clrn  input  1  reset; synchronous, active-low.
REQ-006 prn  input  1  synchronous active-low preset, all channels.
REQ-007 ena  input  WIDTH  per-channel shift enable.
REQ-008 d  input  WIDTH  per-channel serial data in.
REQ-009 slip  input  WIDTH  per-channel slip request, sampled each cycle.
REQ-010 q  output  WIDTH  per-channel selected delayed data.
REQ-011 sel  output  WIDTH*SEL_W  per-channel current tap index, SEL_W = max(1, clog2(DEPTH)).
REQ-012 busy  output  WIDTH  per-channel slip blanking active.
REQ-013 wrap  output  WIDTH  per-channel one-cycle pulse when tap index wraps to 0.

Function
REQ-014 Each channel SHALL hold a DEPTH-stage shift register: on ena=1 stage0<=d, stage[k]<=stage[k-1]; on ena=0 all stages hold.
REQ-015 q SHALL be registered: q<=stage value at index sel after the cycle's shift; with sel=0 and ena=1, q equals d one cycle later.
REQ-016 q SHALL update only on cycles with ena=1; with ena=0, q holds.
REQ-017 A slip SHALL be accepted when slip=1 and busy=0, independent of ena.
REQ-018 Accepted slip: sel<=sel+1 if sel<DEPTH-1, else sel<=0 and wrap<=1 that cycle; new sel governs q from the next enabled cycle.
REQ-019 wrap SHALL be 0 in every cycle without a wrapping accept.
REQ-020 Accepted slip SHALL load guard counter to GUARD; busy=1 while counter nonzero; counter decrements by 1 each cycle regardless of ena.
REQ-021 slip=1 while busy=1 SHALL be ignored (not queued); slip arriving the cycle busy deasserts SHALL be accepted.
REQ-022 Held slip=1 SHALL produce one accept every GUARD+1 cycles.
REQ-023 Channels SHALL be fully independent; no cross-channel timing coupling.

Reset
REQ-024 prn=0 SHALL force all stages and q to 1, sel to 0, counter to 0, busy and wrap to 0; prn takes priority over clrn (legacy priority kept).
REQ-025 clrn=0 with prn=1 SHALL force all stages, q, sel, counter, busy, wrap to 0.
REQ-026 Reset and preset override ena and slip in the same cycle; a slip coincident with either is discarded.
REQ-027 Reset mid-blanking SHALL clear busy immediately; first slip after release is accepted.
REQ-028 Simulation initial state SHALL equal clrn=0 state (all zero).

Structure
REQ-029 Shared package mf_pll_pkg SHALL hold default WIDTH/DEPTH/GUARD constants and a function returning SEL_W from DEPTH.
REQ-030 One sub-module mf_pll_slip_chan SHALL implement a single channel; top instantiates WIDTH copies via generate and concatenates outputs.
REQ-031 No latches, no asynchronous paths; all outputs are direct flop outputs.

Verification
REQ-032 clrn=0 two cycles, then d=1, ena=1, slip=0 -> q=1 on the cycle after first enabled edge, sel=0, busy=0.
REQ-033 DEPTH=8, GUARD=3, ch0 slip pulse x3 spaced 4 cycles, d=walking 1 -> sel=3, q lags d by 4 enabled cycles.
REQ-034 Held slip=1 for 40 cycles, DEPTH=8, GUARD=3 -> accepts every 4th cycle, wrap pulses once when sel 7->0, sel ends at 10 mod 8 = 2.
REQ-035 Slip during busy (cycle 2 after accept) -> ignored, sel unchanged; slip at first busy=0 cycle -> accepted.
REQ-036 ena=0 for 5 cycles while d toggles -> q and stages frozen; slip still accepted, sel advances.
REQ-037 prn=0 and clrn=0 together mid-blanking -> q=all 1, sel=0, busy=0; then clrn=0 alone -> q=0.
